dragon_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the Dragon core's program RAM.
- Consumes a framed byte stream on a valid/ready interface and assembles 36-bit instruction words.
- Writes the words through the RAM write port (port 0 of the 1024-word program RAM, which the core does not drive while held).
- Holds the core stopped until a complete, valid image is loaded, then releases it via CoreRun.

---
 rtl/dragon_loader_if.sv | 24 ++
 rtl/dragon_loader.sv | 191 +++++++++++++++++++
 tb/tb_dragon_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dragon_loader_if.sv
// Boot loader bus: framed byte stream in, program RAM write port and core control out.
// The loader sits on the slave modport; the stream source/RAM/core side uses master.
interface dragon_loader_if;
  logic [7:0]  InData;
  logic        InValid;
  logic        InReady;
  logic        Restart;
  logic        RamWriteEnable;
  logic [9:0]  RamAddress;
  logic [35:0] RamData;
  logic        CoreRun;
  logic        Error;
  logic [1:0]  ErrorCode;

  modport slave (
    input  InData, InValid, Restart,
    output InReady, RamWriteEnable, RamAddress, RamData, CoreRun, Error, ErrorCode
  );

  modport master (
    output InData, InValid, Restart,
    input  InReady, RamWriteEnable, RamAddress, RamData, CoreRun, Error, ErrorCode
  );
endinterface

// File: rtl/dragon_loader.sv
// Dragon boot loader: parses sync/count/word frames into 36-bit program RAM writes.
// Define DRAGON_LOADER_CHECKSUM_EN to require a trailing 8-bit checksum byte per frame.
module dragon_loader #(
  parameter int         WordCount   = 1024,
  parameter int         BaseAddress = 0,
  parameter logic [7:0] SyncByte    = 8'hD7
) (
  input  logic          Clock,
  input  logic          ResetN,
  dragon_loader_if.slave bus
);

  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    COUNT_HI = 3'd1,
    COUNT_LO = 3'd2,
    WORD     = 3'd3,
`ifdef DRAGON_LOADER_CHECKSUM_EN
    CHECK    = 3'd4,
`endif
    DONE     = 3'd5,
    ERROR    = 3'd6
  } state_e;

  localparam logic [9:0]  BaseAddr = 10'(BaseAddress);
  localparam logic [16:0] MaxWords = 17'(WordCount - BaseAddress);

  state_e      state_q;
  logic [15:0] count_q;
  logic [2:0]  byteIdx_q;
  logic [27:0] wordBuf_q;
  logic [9:0]  addr_q;
  logic [35:0] ramData_q;
  logic        wrEn_q;
  logic        inReady_q;
  logic        coreRun_q;
  logic        error_q;
  logic [1:0]  errorCode_q;
`ifdef DRAGON_LOADER_CHECKSUM_EN
  logic [7:0]  checksum_q;
`endif

  logic        accept_d;
  logic [15:0] countFull_d;
  logic        countBad_d;
  logic [35:0] wordDone_d;
  logic        lastWord_d;

  assign accept_d    = bus.InValid && inReady_q;
  assign countFull_d = {count_q[15:8], bus.InData};
  assign countBad_d  = (countFull_d == 16'd0) || ({1'b0, countFull_d} > MaxWords);
  assign wordDone_d  = {wordBuf_q, bus.InData};
  assign lastWord_d  = (count_q == 16'd1);

  // count_q holds the words still to be loaded once the header is parsed.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= SYNC;
      count_q     <= 16'd0;
      byteIdx_q   <= 3'd0;
      wordBuf_q   <= 28'd0;
      addr_q      <= BaseAddr;
      ramData_q   <= 36'd0;
      wrEn_q      <= 1'b0;
      inReady_q   <= 1'b1;
      coreRun_q   <= 1'b0;
      error_q     <= 1'b0;
      errorCode_q <= 2'd0;
`ifdef DRAGON_LOADER_CHECKSUM_EN
      checksum_q  <= 8'd0;
`endif
    end else begin
      wrEn_q <= 1'b0;
      if (wrEn_q) begin
        addr_q <= addr_q + 10'd1;
      end

      case (state_q)
        SYNC: begin
          if (accept_d && (bus.InData == SyncByte)) begin
            state_q <= COUNT_HI;
`ifdef DRAGON_LOADER_CHECKSUM_EN
            checksum_q <= 8'd0;
`endif
          end
        end

        COUNT_HI: begin
          if (accept_d) begin
            count_q[15:8] <= bus.InData;
            state_q       <= COUNT_LO;
          end
        end

        COUNT_LO: begin
          if (accept_d) begin
            if (countBad_d) begin
              state_q     <= ERROR;
              inReady_q   <= 1'b0;
              error_q     <= 1'b1;
              errorCode_q <= 2'd1;
            end else begin
              count_q   <= countFull_d;
              byteIdx_q <= 3'd0;
              addr_q    <= BaseAddr;
              state_q   <= WORD;
            end
          end
        end

        WORD: begin
          if (accept_d) begin
`ifdef DRAGON_LOADER_CHECKSUM_EN
            checksum_q <= checksum_q + bus.InData;
`endif
            if (byteIdx_q == 3'd0) begin
              // Only the low nibble of the lead byte is instruction payload.
              if (bus.InData[7:4] != 4'd0) begin
                state_q     <= ERROR;
                inReady_q   <= 1'b0;
                error_q     <= 1'b1;
                errorCode_q <= 2'd2;
              end else begin
                wordBuf_q <= {24'd0, bus.InData[3:0]};
                byteIdx_q <= 3'd1;
              end
            end else if (byteIdx_q == 3'd4) begin
              ramData_q <= wordDone_d;
              wrEn_q    <= 1'b1;
              byteIdx_q <= 3'd0;
              count_q   <= count_q - 16'd1;
              if (lastWord_d) begin
`ifdef DRAGON_LOADER_CHECKSUM_EN
                state_q <= CHECK;
`else
                state_q   <= DONE;
                inReady_q <= 1'b0;
                coreRun_q <= 1'b1;
`endif
              end
            end else begin
              wordBuf_q <= {wordBuf_q[19:0], bus.InData};
              byteIdx_q <= byteIdx_q + 3'd1;
            end
          end
        end

`ifdef DRAGON_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept_d) begin
            inReady_q <= 1'b0;
            if (bus.InData == checksum_q) begin
              state_q   <= DONE;
              coreRun_q <= 1'b1;
            end else begin
              state_q     <= ERROR;
              error_q     <= 1'b1;
              errorCode_q <= 2'd3;
            end
          end
        end
`endif

        DONE, ERROR: begin
          // Restart overrides the post-write address bump of a final strobe.
          if (bus.Restart) begin
            state_q     <= SYNC;
            inReady_q   <= 1'b1;
            coreRun_q   <= 1'b0;
            error_q     <= 1'b0;
            errorCode_q <= 2'd0;
            addr_q      <= BaseAddr;
          end
        end

        default: begin
          state_q <= SYNC;
        end
      endcase
    end
  end

  assign bus.InReady        = inReady_q;
  assign bus.RamWriteEnable = wrEn_q;
  assign bus.RamAddress     = addr_q;
  assign bus.RamData        = ramData_q;
  assign bus.CoreRun        = coreRun_q;
  assign bus.Error          = error_q;
  assign bus.ErrorCode      = errorCode_q;

endmodule

// File: tb/tb_dragon_loader.sv
// Directed bench for dragon_loader; builds with or without DRAGON_LOADER_CHECKSUM_EN.
module tb_dragon_loader;
  logic clock;
  logic resetN;
  int   checkCount;
  int   errorCount;
  int   strobeCount;
  logic [35:0] ramModel [0:1023];

  dragon_loader_if bus ();

  dragon_loader dut (
    .Clock  (clock),
    .ResetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobes last one full cycle, so sampling them on the falling edge counts each once.
  always @(negedge clock) begin
    if (bus.RamWriteEnable === 1'b1) begin
      ramModel[bus.RamAddress] = bus.RamData;
      strobeCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    bus.InData  = b;
    bus.InValid = 1'b1;
    @(posedge clock);
    #1;
    bus.InValid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulseRestart();
    @(negedge clock);
    bus.Restart = 1'b1;
    @(posedge clock);
    #1;
    bus.Restart = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    #1;
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    strobeCount = 0;
    bus.InData  = 8'h00;
    bus.InValid = 1'b0;
    bus.Restart = 1'b0;
    resetN      = 1'b1;
    #3 resetN = 1'b0;
    #9;
    checkOutput("rstInReady", bus.InReady, 1);
    checkOutput("rstWe", bus.RamWriteEnable, 0);
    checkOutput("rstAddr", bus.RamAddress, 0);
    checkOutput("rstData", bus.RamData, 0);
    checkOutput("rstCoreRun", bus.CoreRun, 0);
    checkOutput("rstError", bus.Error, 0);
    checkOutput("rstCode", bus.ErrorCode, 0);
    @(negedge clock);
    resetN = 1'b1;

    // Two-word frame with leading garbage and a mid-word stall.
    applyStimulus(8'h00);
    checkOutput("garbageReady", bus.InReady, 1);
    applyStimulus(8'hD7);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    idleCycles(3);
    checkOutput("stallNoWe", bus.RamWriteEnable, 0);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    checkOutput("w0We", bus.RamWriteEnable, 1);
    checkOutput("w0Addr", bus.RamAddress, 0);
    checkOutput("w0Data", bus.RamData, 36'h400000001);
    applyStimulus(8'h01);
    checkOutput("w0Single", bus.RamWriteEnable, 0);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("w1We", bus.RamWriteEnable, 1);
    checkOutput("w1Addr", bus.RamAddress, 1);
    checkOutput("w1Data", bus.RamData, 36'h100000000);
`ifdef DRAGON_LOADER_CHECKSUM_EN
    checkOutput("preCsRun", bus.CoreRun, 0);
    applyStimulus(8'h06);
    checkOutput("csNoWe", bus.RamWriteEnable, 0);
`endif
    checkOutput("f1CoreRun", bus.CoreRun, 1);
    checkOutput("f1Error", bus.Error, 0);
    checkOutput("f1Ready", bus.InReady, 0);
    idleCycles(1);
    checkOutput("f1Strobes", strobeCount, 2);
    checkOutput("f1Ram0", ramModel[0], 36'h400000001);
    checkOutput("f1Ram1", ramModel[1], 36'h100000000);
    pulseRestart();
    checkOutput("rsCoreRun", bus.CoreRun, 0);
    checkOutput("rsReady", bus.InReady, 1);
    checkOutput("rsAddr", bus.RamAddress, 0);

    // Zero count.
    applyStimulus(8'hD7);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("cnt0Error", bus.Error, 1);
    checkOutput("cnt0Code", bus.ErrorCode, 1);
    checkOutput("cnt0Ready", bus.InReady, 0);
    idleCycles(1);
    checkOutput("cnt0Strobes", strobeCount, 2);
    pulseRestart();
    checkOutput("cnt0Clear", bus.Error, 0);

    // Count just above and exactly at capacity.
    applyStimulus(8'hD7);
    applyStimulus(8'h04);
    applyStimulus(8'h01);
    checkOutput("cnt401Code", bus.ErrorCode, 1);
    pulseRestart();
    applyStimulus(8'hD7);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    checkOutput("cnt400Error", bus.Error, 0);
    checkOutput("cnt400Ready", bus.InReady, 1);
    doReset();

    // Bad top nibble, then recovery with a good frame.
    applyStimulus(8'hD7);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h14);
    checkOutput("nibError", bus.Error, 1);
    checkOutput("nibCode", bus.ErrorCode, 2);
    idleCycles(1);
    checkOutput("nibStrobes", strobeCount, 2);
    pulseRestart();
    checkOutput("nibRsReady", bus.InReady, 1);
    checkOutput("nibRsError", bus.Error, 0);
    checkOutput("nibRsCode", bus.ErrorCode, 0);
    applyStimulus(8'hD7);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h0A);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    applyStimulus(8'hDD);
    applyStimulus(8'hEE);
    checkOutput("recWe", bus.RamWriteEnable, 1);
    checkOutput("recAddr", bus.RamAddress, 0);
    checkOutput("recData", bus.RamData, 36'hABBCCDDEE);
`ifdef DRAGON_LOADER_CHECKSUM_EN
    applyStimulus(8'h5C);
`endif
    checkOutput("recCoreRun", bus.CoreRun, 1);
    checkOutput("recError", bus.Error, 0);
    pulseRestart();

`ifdef DRAGON_LOADER_CHECKSUM_EN
    // Checksum off by one: word stays written, load fails.
    applyStimulus(8'hD7);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h07);
    applyStimulus(8'h08);
    checkOutput("csError", bus.Error, 1);
    checkOutput("csCode", bus.ErrorCode, 3);
    checkOutput("csCoreRun", bus.CoreRun, 0);
    idleCycles(1);
    checkOutput("csRam0", ramModel[0], 36'h000000007);
    pulseRestart();
`endif

    // Reset in the middle of the second word with InValid held high.
    applyStimulus(8'hD7);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    applyStimulus(8'h05);
    checkOutput("mrW0Data", bus.RamData, 36'h102030405);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    @(negedge clock);
    bus.InData  = 8'h22;
    bus.InValid = 1'b1;
    #2 resetN = 1'b0;
    #1;
    checkOutput("mrReady", bus.InReady, 1);
    checkOutput("mrWe", bus.RamWriteEnable, 0);
    checkOutput("mrAddr", bus.RamAddress, 0);
    checkOutput("mrData", bus.RamData, 0);
    checkOutput("mrCoreRun", bus.CoreRun, 0);
    @(negedge clock);
    bus.InData = 8'h33;
    resetN     = 1'b1;
    idleCycles(2);
    bus.InValid = 1'b0;
    applyStimulus(8'hD7);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h09);
    checkOutput("mrNewWe", bus.RamWriteEnable, 1);
    checkOutput("mrNewAddr", bus.RamAddress, 0);
    checkOutput("mrNewData", bus.RamData, 36'h000000009);
`ifdef DRAGON_LOADER_CHECKSUM_EN
    applyStimulus(8'h09);
`endif
    checkOutput("mrNewRun", bus.CoreRun, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
